alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
Parametrised multi-cycle execute unit for the RV32M/RV64M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in EX beside the single-cycle ALU and its controller.
- Decodes the M-extension from ALUOp/Funct7/Funct3 (ALUOp=2'b10, Funct7=7'b0000001) and computes iteratively, one bit per cycle.
- Raises busy so the hazard unit stalls IF/ID/EX until the result is returned with a one-cycle valid pulse.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  EX stage presents an instruction this cycle.
- ALUOp  input  2  controller op class; only 2'b10 is eligible.
- Funct7  input  7  instruction bits 31:25; must equal 7'b0000001.
- Funct3  input  3  instruction bits 14:12; selects the M operation.
- SrcA  input  XLEN  rs1 operand.
- SrcB  input  XLEN  rs2 operand.
- flush  input  1  synchronous abort of any in-flight operation.
- is_m  output  1  combinational: ALUOp==2'b10 && Funct7==7'b0000001, regardless of in_valid.
- in_ready  output  1  high when state==IDLE.
- busy  output  1  high whenever state!=IDLE, and also combinationally in the accept cycle (in_valid && is_m && IDLE); used as stall.
- out_valid  output  1  one-cycle result strobe.
- Result  output  XLEN  result; holds its value until the next out_valid.

Behaviour:
- Reset (async, high):
  - state=IDLE.
  - Result=0, out_valid=0, internal operand, quotient and product registers and counter cleared.
  - Reset mid-operation discards the operation; no out_valid is produced.
- Accept: when in_valid && is_m && state==IDLE, capture Funct3 and operand magnitudes.
  - Signed ops (MULH rs1 and rs2, MULHSU rs1 only, DIV, REM) use |x| and record the result sign.
- A non-M in_valid is ignored: no state change, no out_valid.
- States:
  - IDLE→CALC on a normal accept; counter=XLEN.
  - IDLE→DONE on a special-case accept.
  - CALC: one step per cycle, counter decrements. At counter==1 the final step completes and the next state is DONE.
  - DONE: out_valid=1 for exactly one cycle, Result registered, then →IDLE.
- Latency:
  - Normal ops: out_valid rises XLEN+1 cycles after the accept edge (33 for XLEN=32).
  - Special cases: 1 cycle after the accept edge.
- Multiply: radix-2 shift-add into a 2·XLEN product, conditionally negated (two's complement) at the end.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, unsigned on magnitudes.
  - Quotient sign = signA^signB; remainder sign = signA.
- Special cases, resolved at accept without iteration:
  - Divisor 0: DIV/DIVU→all ones; REM/REMU→SrcA.
  - Signed overflow (SrcA=most-negative, SrcB=-1): DIV→SrcA; REM→0.
- flush while state!=IDLE: next state IDLE, out_valid suppressed, Result unchanged.
- flush and an accept in the same cycle: flush wins; the instruction is not accepted.
- in_valid while busy: ignored. The stall guarantees EX holds the instruction, so the bench must not expect a re-accept.

Optional Feature:
- FAST_MUL_EN defined:
  - MUL* ops compute with a single combinational XLEN×XLEN multiply and go IDLE→DONE, giving 1-cycle latency.
  - Divide ops are unchanged.
- FAST_MUL_EN undefined: iterative multiply as described above (XLEN+1 latency). No combinational multiplier is inferred.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD (-3), XLEN=32 → Result=0xFFFFFFEB, out_valid exactly 33 cycles after accept, busy high throughout.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH on the same operands → 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7,2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; each with out_valid 1 cycle after accept.
- Start DIV, assert flush at cycle 10 → no out_valid, busy low next cycle, Result unchanged. Repeat with reset at cycle 10 → all outputs 0 immediately.
- in_valid with ALUOp=10, Funct7=0000000 (ADD) → is_m=0, no accept, busy stays 0. With FAST_MUL_EN, MUL 7×-3 → out_valid 1 cycle after accept.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative RV32M/RV64M multiply/divide execute unit.
// Optional macro FAST_MUL_EN: single-cycle combinational multiply path.
module alu_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic            is_m,
    output logic            in_ready,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] Result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              ov_q, ov_d;

    logic              accept;
    logic              sgn_a, sgn_b;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh, div_df;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin;

    assign is_m      = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign in_ready  = (state_q == S_IDLE);
    assign accept    = in_valid && is_m && in_ready && !flush;
    assign busy      = !in_ready || accept;
    assign out_valid = ov_q;
    assign Result    = res_q;

    // Operand sign handling, special cases, one iteration step, final fix-up
    always_comb begin
        sgn_a    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sgn_b    = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                   (Funct3 == 3'b110);
        neg_a    = sgn_a && SrcA[XLEN-1];
        neg_b    = sgn_b && SrcB[XLEN-1];
        mag_a    = neg_a ? (~SrcA + 1'b1) : SrcA;
        mag_b    = neg_b ? (~SrcB + 1'b1) : SrcB;
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] &&
                   (SrcA == MIN_NEG) && (SrcB == '1);

        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_sh   = {acc_q, lo_q[XLEN-1]};
        div_df   = div_sh - {1'b0, opd_q};

        prod_s   = negq_q ? (~{acc_q, lo_q} + 1'b1) : {acc_q, lo_q};
        quo_s    = negq_q ? (~lo_q + 1'b1) : lo_q;
        rem_s    = negr_q ? (~acc_q + 1'b1) : acc_q;

        if (op_q[2])
            fin = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            fin = prod_s[XLEN-1:0];
        else
            fin = prod_s[2*XLEN-1:XLEN];
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        ov_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = Funct3;
                    negq_d = neg_a ^ neg_b;
                    negr_d = neg_a;
                    cnt_d  = CNT_W'(XLEN);
                    if (Funct3[2]) begin
                        if (div_zero) begin
                            lo_d    = '1;
                            acc_d   = SrcA;
                            negq_d  = 1'b0;
                            negr_d  = 1'b0;
                            state_d = S_DONE;
                        end else if (div_ovf) begin
                            lo_d    = SrcA;
                            acc_d   = '0;
                            negq_d  = 1'b0;
                            negr_d  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            acc_d   = '0;
                            lo_d    = mag_a;
                            opd_d   = mag_b;
                            state_d = S_CALC;
                        end
                    end else begin
`ifdef FAST_MUL_EN
                        {acc_d, lo_d} = {{XLEN{1'b0}}, mag_a} *
                                        {{XLEN{1'b0}}, mag_b};
                        state_d = S_DONE;
`else
                        acc_d   = '0;
                        lo_d    = mag_b;
                        opd_d   = mag_a;
                        state_d = S_CALC;
`endif
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[2]) begin
                        if (!div_df[XLEN]) begin
                            acc_d = div_df[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = div_sh[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {acc_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush) begin
                    ov_d  = 1'b1;
                    res_d = fin;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: scoreboard bench for alu_muldiv_unit (XLEN=32).
// Directed vectors with hand-computed results and latencies.
module tb_alu_muldiv_unit;

    localparam int XLEN = 32;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [1:0]      ALUOp = 2'b00;
    logic [6:0]      Funct7 = 7'b0;
    logic [2:0]      Funct3 = 3'b0;
    logic [XLEN-1:0] SrcA = '0;
    logic [XLEN-1:0] SrcB = '0;
    logic            flush = 1'b0;
    logic            is_m, in_ready, busy, out_valid;
    logic [XLEN-1:0] Result;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ov_seen = 0;
    logic [31:0] last_res = '0;

    alu_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .is_m(is_m), .in_ready(in_ready), .busy(busy),
        .out_valid(out_valid), .Result(Result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop expected entry on each result strobe
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            ov_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid got=%h", Result);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (Result !== e.res) begin
                    errors++;
                    $display("FAIL result got=%h exp=%h", Result, e.res);
                end
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency got_cyc=%0d exp_cyc=%0d",
                             cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, output int acc_cyc);
        @(negedge clk);
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Funct7   = 7'b0000001;
        Funct3   = f3;
        SrcA     = a;
        SrcB     = b;
        #1;
        check("accept_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int   ac;
        logic busy_bad;
        logic done;
        busy_bad = 1'b0;
        done     = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Funct7   = 7'b0000001;
        Funct3   = f3;
        SrcA     = a;
        SrcB     = b;
        @(posedge clk);
        #1;
        ac = cyc;
        sb.push_back('{res: exp, cyc: ac + lat});
        last_res = exp;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            if (!out_valid && !busy) busy_bad = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d", name, sb.size());
            sb.delete();
        end
        check({name, "_busy_gap"}, {31'b0, busy_bad}, 32'd0);
    endtask

    initial begin
        int ac;
        int ov0;
        #1;
        check("rst_result", Result, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue("mul",    3'b000, 32'd7,        32'hFFFFFFFD,
              32'hFFFFFFEB, MUL_LAT);
        issue("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, MUL_LAT);
        issue("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000000, MUL_LAT);
        issue("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,
              32'hFFFFFFFF, MUL_LAT);
        issue("mulh_min", 3'b001, 32'h80000000, 32'h80000000,
              32'h40000000, MUL_LAT);
        issue("div",    3'b100, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFD, DIV_LAT);
        issue("rem",    3'b110, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, DIV_LAT);
        issue("div_nb", 3'b100, 32'd7,        32'hFFFFFFFE,
              32'hFFFFFFFD, DIV_LAT);
        issue("rem_nb", 3'b110, 32'd7,        32'hFFFFFFFE,
              32'd1, DIV_LAT);
        issue("divu",   3'b101, 32'd100,      32'd7,
              32'd14, DIV_LAT);
        issue("remu",   3'b111, 32'd100,      32'd7,
              32'd2, DIV_LAT);
        issue("divu0",  3'b101, 32'd5,        32'd0,
              32'hFFFFFFFF, 1);
        issue("remu0",  3'b111, 32'd5,        32'd0,
              32'd5, 1);
        issue("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
              32'h80000000, 1);
        issue("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
              32'd0, 1);

        // Flush mid-divide
        ov0 = ov_seen;
        start_op(3'b100, 32'd100, 32'd7, ac);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("flush_no_ov", ov_seen - ov0, 32'd0);
        check("flush_result", Result, last_res);

        // Non-M instruction is ignored
        ov0 = ov_seen;
        @(negedge clk);
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Funct7   = 7'b0000000;
        Funct3   = 3'b000;
        SrcA     = 32'd3;
        SrcB     = 32'd4;
        #1;
        check("add_is_m", {31'b0, is_m}, 32'd0);
        check("add_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("add_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("add_no_ov", ov_seen - ov0, 32'd0);

        // Reset mid-divide
        ov0 = ov_seen;
        start_op(3'b100, 32'd100, 32'd7, ac);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_result", Result, 32'd0);
        check("rst_mid_ov", {31'b0, out_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("rst_no_ov", ov_seen - ov0, 32'd0);

        issue("divu_again", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
